// File: rtl/uart_frame_rx.sv
// Buffered UART receiver: 2-flop synchroniser, framing FSM with optional parity, output FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_frame_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int PARITY     = 0,
    parameter int DO_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rx,
    output logic [DO_WIDTH-1:0] dout,
    output logic                dout_vld,
    input  logic                dout_rdy,
    output logic [2:0]          err_out
);

    localparam int CLKIN_DIV = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = CLKIN_DIV / 2;
    localparam int CNT_W     = $clog2(CLKIN_DIV);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int OCC_W     = PTR_W + 1;
    localparam bit PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rxs;
    logic [CNT_W-1:0]     cnt;
    logic                 tick;
    logic                 samp_en, samp_bit;
    logic [DO_WIDTH-1:0]  sh;
    logic [3:0]           bit_cnt;
    logic                 par_bad;
    logic                 shift_en, par_chk, push_req, frame_err, par_err;
    logic                 pop, push, full, ovf;
    logic [DO_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [OCC_W-1:0]     count;

    // NOTE: state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    // Baud counter is parked at HALF-1 while idle so START samples mid start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == S_IDLE) begin
            cnt <= CNT_W'(HALF - 1);
        end else if (state != S_BREAK) begin
            cnt <= (cnt == '0) ? CNT_W'(CLKIN_DIV - 1) : cnt - 1'b1;
        end
    end

    assign tick = (state inside {S_START, S_DATA, S_PAR, S_STOP}) && (cnt == '0);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    logic       tick_d;

    // Decision lands one cycle after the centre, once the centre+1 sample is on rxs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist   <= 2'b11;
            tick_d <= 1'b0;
        end else begin
            hist   <= {hist[0], rxs};
            tick_d <= tick;
        end
    end

    assign samp_en  = tick_d;
    assign samp_bit = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
    assign samp_en  = tick;
    assign samp_bit = rxs;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        push_req  = 1'b0;
        frame_err = 1'b0;
        par_err   = 1'b0;
        unique case (state)
            S_IDLE:  if (!rxs) state_nxt = S_START;
            S_START: if (samp_en) state_nxt = samp_bit ? S_IDLE : S_DATA;
            S_DATA: begin
                if (samp_en) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'(DO_WIDTH - 1))
                        state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (samp_en) begin
                    par_chk   = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (samp_en) begin
                    if (!samp_bit) begin
                        frame_err = 1'b1;
                        state_nxt = S_BREAK;
                    end else begin
                        par_err   = par_bad;
                        push_req  = !par_bad;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_BREAK: if (rxs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh      <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end
            if (shift_en) begin
                sh      <= {samp_bit, sh[DO_WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_chk)
                par_bad <= samp_bit ^ (^sh) ^ PAR_ODD;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign dout_vld = (count != '0);
    assign full     = (count == OCC_W'(FIFO_DEPTH));
    assign pop      = dout_vld && dout_rdy;
    assign push     = push_req && (!full || pop);
    assign ovf      = push_req && full && !pop;
    assign dout     = dout_vld ? mem[rd_ptr] : '0;

    // NOTE: the storage array has no reset; an entry is only visible after it is written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_out <= '0;
        else      err_out <= {ovf, par_err, frame_err};
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: one no-parity instance and one even-parity instance.
module tb_uart_frame_rx;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       dout_rdy = 1'b1;
    logic [7:0] dout, dout_p;
    logic       dout_vld, dout_vld_p;
    logic [2:0] err_out, err_out_p;

    int passed = 0;
    int total  = 0;

    logic [7:0] got[$];
    logic [7:0] got_p[$];
    int vld_cycles = 0;
    int n_ferr = 0, n_perr = 0, n_ovf = 0;
    int n_ferr_p = 0, n_perr_p = 0;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(0), .DO_WIDTH(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(rx),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .err_out(err_out)
    );

    uart_frame_rx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1), .DO_WIDTH(8), .FIFO_DEPTH(4)
    ) dut_p (
        .clk(clk), .rst(rst), .uart_rx(rx_p),
        .dout(dout_p), .dout_vld(dout_vld_p), .dout_rdy(1'b1), .err_out(err_out_p)
    );

    always @(negedge clk) begin
        if (dout_vld) vld_cycles++;
        if (dout_vld && dout_rdy) got.push_back(dout);
        if (dout_vld_p) got_p.push_back(dout_p);
        if (err_out[0]) n_ferr++;
        if (err_out[1]) n_perr++;
        if (err_out[2]) n_ovf++;
        if (err_out_p[0]) n_ferr_p++;
        if (err_out_p[1]) n_perr_p++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input bit p, input logic v);
        if (p) rx_p = v;
        else   rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send(input bit p, input logic [7:0] data, input bit use_par,
                        input bit par_bit, input bit stop_bit);
        drive(p, 1'b0);
        for (int i = 0; i < 8; i++) drive(p, data[i]);
        if (use_par) drive(p, par_bit);
        drive(p, stop_bit);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        rx_p = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ferr0, perr0, ovf0;
        logic [7:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_vld", {31'b0, dout_vld}, 32'h0);
        check("reset_dout", {24'b0, dout}, 32'h0);
        check("reset_err", {29'b0, err_out}, 32'h0);
        rst = 1'b1;
        idle(20);

        // Back-to-back frames
        vld_cycles = 0;
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(30);
        check("b2b_count", got.size(), 2);
        d = (got.size() > 0) ? got[0] : 8'hxx;
        check("b2b_word0", {24'b0, d}, 32'hA5);
        d = (got.size() > 1) ? got[1] : 8'hxx;
        check("b2b_word1", {24'b0, d}, 32'h3C);
        check("b2b_vld_cycles", vld_cycles, 2);
        check("b2b_no_err", n_ferr + n_perr + n_ovf, 0);
        got.delete();

        // Short low glitch is a false start
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check("glitch_no_word", got.size(), 0);
        check("glitch_no_err", n_ferr + n_perr + n_ovf, 0);

        // Stop bit low, line held low, then a good frame
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(30);
        check("break_ferr_once", n_ferr, 1);
        check("break_no_word", got.size(), 0);
        check("break_no_perr", n_perr, 0);
        send(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        idle(30);
        check("after_break_count", got.size(), 1);
        d = (got.size() > 0) ? got[0] : 8'hxx;
        check("after_break_word", {24'b0, d}, 32'h12);
        got.delete();

        // Even parity: 0x07 has three ones, so the parity bit must be 1
        send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle(30);
        check("par_bad_perr", n_perr_p, 1);
        check("par_bad_no_word", got_p.size(), 0);
        check("par_bad_no_ferr", n_ferr_p, 0);
        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(30);
        check("par_ok_count", got_p.size(), 1);
        d = (got_p.size() > 0) ? got_p[0] : 8'hxx;
        check("par_ok_word", {24'b0, d}, 32'h07);
        check("par_ok_no_new_perr", n_perr_p, 1);

        // Overrun on the fifth frame with the consumer stalled
        dout_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        idle(30);
        check("ovf_once", n_ovf, 1);
        check("ovf_head_vld", {31'b0, dout_vld}, 32'h1);
        check("ovf_head_word", {24'b0, dout}, 32'h01);
        dout_rdy = 1'b1;
        idle(10);
        check("drain_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            d = (got.size() > i) ? got[i] : 8'hxx;
            check($sformatf("drain_word%0d", i), {24'b0, d}, i + 1);
        end
        check("drain_empty", {31'b0, dout_vld}, 32'h0);
        got.delete();

        // Reset mid-frame with two words queued
        dout_rdy = 1'b0;
        send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        idle(20);
        check("pre_rst_vld", {31'b0, dout_vld}, 32'h1);
        ferr0 = n_ferr;
        perr0 = n_perr;
        ovf0  = n_ovf;
        d = 8'h33;
        drive(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, d[i]);
        rx = d[4];
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_vld_drop", {31'b0, dout_vld}, 32'h0);
        check("rst_dout_zero", {24'b0, dout}, 32'h0);
        check("rst_err_zero", {29'b0, err_out}, 32'h0);
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        dout_rdy = 1'b1;
        idle(30);
        check("rst_no_err", (n_ferr - ferr0) + (n_perr - perr0) + (n_ovf - ovf0), 0);
        check("rst_no_word", got.size(), 0);
        send(1'b0, 8'h9E, 1'b0, 1'b0, 1'b1);
        idle(30);
        check("post_rst_count", got.size(), 1);
        d = (got.size() > 0) ? got[0] : 8'hxx;
        check("post_rst_word", {24'b0, d}, 32'h9E);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
